// File: rtl/rgb_to_gray_pipe.sv
// rgb_to_gray_pipe: AXI4-Stream RGB to grayscale converter, PPC pixels per beat.
// Two-stage stallable pipeline. Stage 1 holds the weighted sums and bypass data.
// Stage 2 holds the rounded and saturated result on m_axis_*.
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   mode                   0=BT.601, 1=BT.709, 2=average, 3=bypass (sampled on SOF beats)
//   s_axis_*               input stream, per pixel R low, G middle, B high; tuser=SOF, tlast=EOL
//   m_axis_*               output stream, gray per pixel (x3 when OUT_RGB=1)
//   frame_cnt              count of SOF beats handed off at the output
module rgb_to_gray_pipe #(
    parameter int unsigned PPC     = 1,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OUT_RGB = 1,
    parameter int unsigned FCNT_W  = 16
) (
    input  logic                                          aclk,
    input  logic                                          areset,
    input  logic [1:0]                                    mode,
    input  logic                                          s_axis_tvalid,
    input  logic [PPC*3*DATA_W-1:0]                       s_axis_tdata,
    input  logic                                          s_axis_tlast,
    input  logic                                          s_axis_tuser,
    output logic                                          s_axis_tready,
    output logic                                          m_axis_tvalid,
    output logic [PPC*((OUT_RGB != 0) ? 3 : 1)*DATA_W-1:0] m_axis_tdata,
    output logic                                          m_axis_tlast,
    output logic                                          m_axis_tuser,
    input  logic                                          m_axis_tready,
    output logic [FCNT_W-1:0]                             frame_cnt
);

    localparam int unsigned CPP   = (OUT_RGB != 0) ? 3 : 1;
    localparam int unsigned OPW   = CPP * DATA_W;
    localparam int unsigned OUT_W = PPC * OPW;
    localparam int unsigned SUM_W = DATA_W + 10;
    localparam logic [DATA_W-1:0] MAX_PIX = '1;

    // Packed {Cr, Cg, Cb} weights, each an 8-bit fraction of 256.
    function automatic logic [23:0] coef(input logic [1:0] m);
        case (m)
            2'd0:    coef = {8'd77, 8'd150, 8'd29};
            2'd1:    coef = {8'd54, 8'd183, 8'd19};
            2'd2:    coef = {8'd85, 8'd85,  8'd86};
            default: coef = 24'd0;
        endcase
    endfunction

    logic                   advance;
    logic [1:0]             act_mode;
    logic [1:0]             eff_mode;
    logic [PPC*SUM_W-1:0]   sum_c;
    logic [OUT_W-1:0]       byp_c;
    logic [OUT_W-1:0]       out_c;

    logic                   s1_valid;
    logic [PPC*SUM_W-1:0]   s1_sum;
    logic [OUT_W-1:0]       s1_byp;
    logic                   s1_last;
    logic                   s1_user;
    logic [1:0]             s1_mode;

    // Whole pipe moves together; bubbles are kept, never squeezed out.
    assign advance       = m_axis_tready | ~m_axis_tvalid;
    assign s_axis_tready = advance;

    // Stage 1 inputs: effective mode, weighted sums and bypass payload.
    always_comb begin
        logic [23:0]       cf;
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
        eff_mode = s_axis_tuser ? mode : act_mode;
        cf       = coef(eff_mode);
        sum_c    = '0;
        byp_c    = '0;
        r        = '0;
        g        = '0;
        b        = '0;
        for (int unsigned p = 0; p < PPC; p++) begin
            r = s_axis_tdata[p*3*DATA_W +: DATA_W];
            g = s_axis_tdata[p*3*DATA_W + DATA_W +: DATA_W];
            b = s_axis_tdata[p*3*DATA_W + 2*DATA_W +: DATA_W];
            sum_c[p*SUM_W +: SUM_W] = SUM_W'(cf[23:16]) * SUM_W'(r)
                                    + SUM_W'(cf[15:8])  * SUM_W'(g)
                                    + SUM_W'(cf[7:0])   * SUM_W'(b);
            if (OUT_RGB != 0)
                byp_c[p*OPW +: OPW] = OPW'(s_axis_tdata[p*3*DATA_W +: 3*DATA_W]);
            else
                byp_c[p*OPW +: OPW] = OPW'(g);
        end
    end

    // Stage 2 inputs: round to nearest, saturate, replicate or bypass.
    always_comb begin
        logic [SUM_W-1:0]  shifted;
        logic [DATA_W-1:0] gray;
        out_c   = '0;
        shifted = '0;
        gray    = '0;
        for (int unsigned p = 0; p < PPC; p++) begin
            shifted = (s1_sum[p*SUM_W +: SUM_W] + SUM_W'(128)) >> 8;
            gray    = (shifted > SUM_W'(MAX_PIX)) ? MAX_PIX : shifted[DATA_W-1:0];
            if (s1_mode == 2'd3)
                out_c[p*OPW +: OPW] = s1_byp[p*OPW +: OPW];
            else
                out_c[p*OPW +: OPW] = OPW'({CPP{gray}});
        end
    end

    // Pipeline registers; everything holds while the output is stalled.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            act_mode      <= 2'd0;
            s1_valid      <= 1'b0;
            s1_sum        <= '0;
            s1_byp        <= '0;
            s1_last       <= 1'b0;
            s1_user       <= 1'b0;
            s1_mode       <= 2'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (advance) begin
            s1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1_sum  <= sum_c;
                s1_byp  <= byp_c;
                s1_last <= s_axis_tlast;
                s1_user <= s_axis_tuser;
                s1_mode <= eff_mode;
                if (s_axis_tuser)
                    act_mode <= mode;
            end
            m_axis_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axis_tdata <= out_c;
                m_axis_tlast <= s1_last;
                m_axis_tuser <= s1_user;
            end
        end
    end

    // Frames counted as their SOF beat leaves the block.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            frame_cnt <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tuser)
            frame_cnt <= frame_cnt + FCNT_W'(1);
    end

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Testbench for rgb_to_gray_pipe: scoreboard with a reference model.
// Instance a: PPC=1, OUT_RGB=1 (random output stalls). Instance b: PPC=2, OUT_RGB=0.
module tb_rgb_to_gray_pipe;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset;
    logic [1:0]  mode;
    logic        s_tvalid, s_tlast, s_tuser, s_tready;
    logic [23:0] s_tdata;
    logic        m_tvalid, m_tlast, m_tuser, m_tready;
    logic [23:0] m_tdata;
    logic [15:0] frame_cnt;

    logic [1:0]  b_mode;
    logic        b_svalid, b_slast, b_suser, b_sready;
    logic [47:0] b_sdata;
    logic        b_mvalid, b_mlast, b_muser;
    logic        b_mready;
    logic [15:0] b_mdata;
    logic [15:0] b_fcnt;

    rgb_to_gray_pipe #(.PPC(1), .DATA_W(8), .OUT_RGB(1), .FCNT_W(16)) u_a (
        .aclk(aclk), .areset(areset), .mode(mode),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready), .frame_cnt(frame_cnt)
    );

    rgb_to_gray_pipe #(.PPC(2), .DATA_W(8), .OUT_RGB(0), .FCNT_W(16)) u_b (
        .aclk(aclk), .areset(areset), .mode(b_mode),
        .s_axis_tvalid(b_svalid), .s_axis_tdata(b_sdata), .s_axis_tlast(b_slast),
        .s_axis_tuser(b_suser), .s_axis_tready(b_sready),
        .m_axis_tvalid(b_mvalid), .m_axis_tdata(b_mdata), .m_axis_tlast(b_mlast),
        .m_axis_tuser(b_muser), .m_axis_tready(b_mready), .frame_cnt(b_fcnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [25:0] qa[$];
    logic [17:0] qb[$];
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 toggle
    logic [1:0]  model_mode_a = 2'd0;
    logic [1:0]  model_mode_b = 2'd0;
    logic [15:0] exp_fcnt = 16'd0;
    logic        held = 1'b0;
    logic [25:0] held_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Luma from plain integer arithmetic: weighted sum, round half up, clamp.
    function automatic int gray_ref(input int m, input int r, input int g, input int b);
        int v;
        case (m)
            0:       v = (77 * r + 150 * g + 29 * b + 128) / 256;
            1:       v = (54 * r + 183 * g + 19 * b + 128) / 256;
            default: v = (85 * r + 85 * g + 86 * b + 128) / 256;
        endcase
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic logic [23:0] exp_a(input logic [1:0] m, input logic [23:0] px);
        logic [7:0] gv;
        if (m == 2'd3) return px;
        gv = 8'(gray_ref(int'(m), int'(px[7:0]), int'(px[15:8]), int'(px[23:16])));
        return {gv, gv, gv};
    endfunction

    function automatic logic [15:0] exp_b(input logic [1:0] m, input logic [47:0] d);
        logic [15:0] o;
        logic [23:0] px;
        o = '0;
        for (int p = 0; p < 2; p++) begin
            px = d[p*24 +: 24];
            if (m == 2'd3) o[p*8 +: 8] = px[15:8];
            else o[p*8 +: 8] = 8'(gray_ref(int'(m), int'(px[7:0]), int'(px[15:8]), int'(px[23:16])));
        end
        return o;
    endfunction

    // Present one beat on instance a; the expectation is queued once acceptance is certain.
    task automatic send_a(input logic [23:0] d, input logic last, input logic user,
                          input logic [1:0] md, input bit has_exp, input logic [23:0] ex);
        logic [1:0] eff;
        @(negedge aclk);
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tuser = user; mode = md;
        for (int n = 0; ; n++) begin
            #1;
            if (s_tready) break;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL send_a_timeout actual=stalled required=accept");
                return;
            end
            @(negedge aclk);
        end
        eff = user ? md : model_mode_a;
        if (user) model_mode_a = md;
        qa.push_back({last, user, has_exp ? ex : exp_a(eff, d)});
        @(posedge aclk);
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge aclk);
            s_tvalid = 1'b0;
        end
    endtask

    task automatic drain_a();
        for (int n = 0; n < 500; n++) begin
            @(negedge aclk);
            #2;
            if (qa.size() == 0 && !m_tvalid) return;
        end
        checks++; failures++;
        $display("FAIL drain_a_timeout actual=%0d required=0", qa.size());
    endtask

    task automatic send_b(input logic [47:0] d, input logic last, input logic user,
                          input logic [1:0] md, input bit has_exp, input logic [15:0] ex);
        logic [1:0] eff;
        @(negedge aclk);
        b_svalid = 1'b1; b_sdata = d; b_slast = last; b_suser = user; b_mode = md;
        for (int n = 0; ; n++) begin
            #1;
            if (b_sready) break;
            if (n > 200) begin
                checks++; failures++;
                $display("FAIL send_b_timeout actual=stalled required=accept");
                return;
            end
            @(negedge aclk);
        end
        eff = user ? md : model_mode_b;
        if (user) model_mode_b = md;
        qb.push_back({last, user, has_exp ? ex : exp_b(eff, d)});
        @(posedge aclk);
    endtask

    // Monitor a: drives m_tready, checks order, stall stability and frame_cnt.
    initial begin
        logic [25:0] cur;
        forever begin
            @(negedge aclk);
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = ~m_tready;
            endcase
            #1;
            if (areset) begin
                held = 1'b0;
                continue;
            end
            cur = {m_tlast, m_tuser, m_tdata};
            check("frame_cnt", 64'(frame_cnt), 64'(exp_fcnt));
            if (held) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_stable", 64'(cur), 64'(held_val));
            end
            if (m_tvalid && m_tready) begin
                held = 1'b0;
                if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat_a actual=%0h required=none", cur);
                end else begin
                    check("beat_a", 64'(cur), 64'(qa.pop_front()));
                end
                if (m_tuser) exp_fcnt = exp_fcnt + 16'd1;
            end else if (m_tvalid) begin
                held = 1'b1;
                held_val = cur;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Monitor b: always ready, every valid beat is a handshake.
    initial begin
        logic [17:0] cur;
        forever begin
            @(negedge aclk);
            #1;
            if (areset) continue;
            if (b_mvalid) begin
                cur = {b_mlast, b_muser, b_mdata};
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat_b actual=%0h required=none", cur);
                end else begin
                    check("beat_b", 64'(cur), 64'(qb.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        mode = 2'd0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        m_tready = 1'b1;
        b_mode = 2'd0; b_svalid = 1'b0; b_sdata = '0; b_slast = 1'b0; b_suser = 1'b0;
        b_mready = 1'b1;
        #12;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        check("rst_side", 64'({m_tlast, m_tuser}), 64'd0);
        check("rst_fcnt", 64'(frame_cnt), 64'd0);
        @(negedge aclk);
        areset = 1'b0;

        fork
            begin
                // Latency: accept at one edge, valid after the second edge.
                send_a(24'h0000FF, 1'b0, 1'b1, 2'd0, 1'b1, 24'h4D4D4D);
                #1;
                s_tvalid = 1'b0;
                check("latency_1", 64'(m_tvalid), 64'd0);
                @(posedge aclk);
                #1;
                check("latency_2", 64'(m_tvalid), 64'd1);
                drain_a();

                send_a(24'h00FF00, 1'b0, 1'b1, 2'd1, 1'b1, 24'hB6B6B6);
                send_a(24'hFFFFFF, 1'b0, 1'b0, 2'd1, 1'b1, 24'hFFFFFF);
                send_a(24'hFFFFFF, 1'b0, 1'b1, 2'd0, 1'b1, 24'hFFFFFF);
                send_a(24'hFFFFFF, 1'b0, 1'b1, 2'd2, 1'b1, 24'hFFFFFF);
                send_a(24'h123456, 1'b0, 1'b1, 2'd3, 1'b1, 24'h123456);
                // Mode change mid-line only takes effect at the next SOF.
                send_a(24'h0000FF, 1'b0, 1'b1, 2'd0, 1'b1, 24'h4D4D4D);
                send_a(24'h0000FF, 1'b0, 1'b0, 2'd1, 1'b1, 24'h4D4D4D);
                send_a(24'h0000FF, 1'b1, 1'b0, 2'd1, 1'b1, 24'h4D4D4D);
                send_a(24'h0000FF, 1'b0, 1'b1, 2'd1, 1'b1, 24'h363636);
                idle_a(1);
                drain_a();

                // 8-beat line under a toggling ready.
                ready_mode = 2;
                for (int i = 0; i < 8; i++)
                    send_a(24'($urandom()), 1'(i == 7), 1'(i == 0), 2'd0, 1'b0, '0);
                idle_a(1);
                ready_mode = 0;
                drain_a();

                // Random traffic with random stalls, gaps, SOF/EOL and modes.
                ready_mode = 1;
                for (int i = 0; i < 300; i++) begin
                    send_a(24'($urandom()), 1'($urandom_range(0, 7) == 0),
                           1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), 1'b0, '0);
                    if ($urandom_range(0, 4) == 0) idle_a(int'($urandom_range(1, 3)));
                end
                idle_a(1);
                ready_mode = 0;
                drain_a();
            end
            begin
                send_b(48'h000000_FFFFFF, 1'b0, 1'b1, 2'd0, 1'b1, 16'h00FF);
                send_b({24'hABCDEF, 24'h123456}, 1'b1, 1'b1, 2'd3, 1'b1, 16'hCD34);
                for (int i = 0; i < 40; i++)
                    send_b({24'($urandom()), 24'($urandom())}, 1'($urandom_range(0, 5) == 0),
                           1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 1'b0, '0);
                @(negedge aclk);
                b_svalid = 1'b0;
                repeat (4) @(negedge aclk);
            end
        join
        check("qb_empty", 64'(qb.size()), 64'd0);

        // Reset with two beats in flight.
        send_a(24'($urandom()), 1'b0, 1'b1, 2'd2, 1'b0, '0);
        send_a(24'($urandom()), 1'b0, 1'b0, 2'd2, 1'b0, '0);
        #2;
        s_tvalid = 1'b0;
        areset = 1'b1;
        #1;
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_fcnt", 64'(frame_cnt), 64'd0);
        check("midrst_tdata", 64'(m_tdata), 64'd0);
        qa.delete();
        held = 1'b0;
        exp_fcnt = 16'd0;
        model_mode_a = 2'd0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;

        // First beats after reset fall back to BT.601.
        send_a(24'h0000FF, 1'b0, 1'b0, 2'd2, 1'b1, 24'h4D4D4D);
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++)
                send_a(24'($urandom()), 1'(i == 3), 1'(i == 0), 2'(f), 1'b0, '0);
        idle_a(1);
        drain_a();
        @(negedge aclk);
        check("frame_cnt_3", 64'(frame_cnt), 64'd3);
        check("qa_empty", 64'(qa.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_to_gray_pipe.md
Name: rgb_to_gray_pipe

Overview:
- Parametrised successor to the single-pixel AXI4-Stream RGB-to-grayscale stage.
- Converts PPC pixels per beat using selectable luma weightings: BT.601, BT.709, average, or bypass.
- Uses a 2-stage stallable multiply/round pipeline with optional 3-channel replication and a frame counter.
- Sits in the video pipe between the input stream (tuser = SOF, tlast = EOL) and downstream VDMA/display logic.

Parameters:
PPC, 1, pixels per beat (1..4); pixel p occupies s_axis_tdata[p*3*DATA_W +: 3*DATA_W].
DATA_W, 8, bits per colour component (8..12).
OUT_RGB, 1, 1 = output gray replicated to three components per pixel; 0 = one component per pixel.
FCNT_W, 16, width of frame counter.

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
mode  in  2  conversion mode; sampled only on SOF beats
s_axis_tvalid  in  1  input valid
s_axis_tdata  in  PPC*3*DATA_W  per pixel: R [DATA_W-1:0], G next, B top
s_axis_tlast  in  1  end of line
s_axis_tuser  in  1  start of frame
s_axis_tready  out  1  input ready
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  PPC*(OUT_RGB?3:1)*DATA_W  gray pixels, same pixel order as input
m_axis_tlast  out  1  delayed tlast
m_axis_tuser  out  1  delayed tuser
m_axis_tready  in  1  output ready
frame_cnt  out  FCNT_W  count of SOF beats accepted at output

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-high on areset. While areset is high:
  - both stage valids = 0 and m_axis_tvalid = 0;
  - m_axis_tdata, tlast and tuser = 0;
  - frame_cnt = 0;
  - active mode register = 0 (BT.601).
- Coefficients (Cr, Cg, Cb, each 8-bit fraction /256):
  - mode 0 = 77/150/29
  - mode 1 = 54/183/19
  - mode 2 = 85/85/86
  - mode 3 = bypass
- Arithmetic, per pixel:
  - sum = Cr*R + Cg*G + Cb*B, computed in DATA_W+10 bits;
  - gray = (sum + 128) >> 8, saturated to 2^DATA_W-1.
- Bypass output:
  - OUT_RGB=1: input R,G,B passed unchanged;
  - OUT_RGB=0: G component passed.
- OUT_RGB=1 normal modes output {gray,gray,gray} per pixel.
- Pipeline structure:
  - Stage 1 registers products plus sideband (tlast, tuser, effective mode).
  - Stage 2 registers rounded/saturated result onto m_axis_*.
- Latency and throughput: 2 cycles from an accepted input beat to m_axis_tvalid; sustained 1 beat/cycle when m_axis_tready stays high.
- Stall rule:
  - advance = m_axis_tready | ~m_axis_tvalid; s_axis_tready = advance (combinational path from m_axis_tready permitted).
  - When advance = 0, all stage registers hold.
  - Bubbles do not compress.
- AXIS rule: once m_axis_tvalid = 1, m_axis_tdata, tlast and tuser stay stable until the handshake completes.
- Mode sampling:
  - On an accepted beat with s_axis_tuser=1, effective mode = mode input, and the active mode register loads it.
  - All other beats use the active mode register; mode changes mid-frame take effect at the next SOF.
- Sideband: tlast and tuser travel with their data beat unchanged.
- frame_cnt:
  - increments on the output handshake (m_axis_tvalid & m_axis_tready & m_axis_tuser);
  - wraps from 2^FCNT_W-1 to 0.
- Simultaneous input accept and output accept in one cycle: both occur, no loss.
- Reset mid-frame: in-flight beats are discarded; output resumes cleanly after deassertion; the next frame is converted in mode 0 unless its SOF carries another mode.

Test Plan:
- PPC=1, mode 0 on SOF, R=255 G=0 B=0 -> gray 77, m_tdata=0x4D4D4D, m_tuser=1, valid 2 cycles after accept.
- Mode 1, R=0 G=255 B=0 -> 182; white 0xFFFFFF -> 0xFFFFFF in modes 0/1/2; mode 3, 0x123456 -> 0x123456.
- Mode input changed 0->1 mid-line -> following pixels still use BT.601; next SOF beat with mode=1 uses BT.709.
- Stream 8 beats with m_axis_tready toggling 1/0 each cycle -> all 8 outputs in order, data stable while stalled, tlast on beat 8 only.
- PPC=2, OUT_RGB=0, input {white, black} -> m_tdata=0x00FF.
- Assert areset with 2 beats in flight -> m_tvalid=0 immediately, frame_cnt=0; 3 SOF frames after release -> frame_cnt=3.
